// File: rtl/spike_address_tx.sv
// Serialises a captured fired-neuron bitmap, lowest index first, into held 12-bit source addresses.
// First address 2 edges after spike_load; each address is held HOLD_CYCLES clear-low cycles, and the hold stalls while clear is high.
module spike_address_tx #(
    parameter int                   NUM_NEURONS  = 8,
    parameter int                   ADDR_BITS    = 12,
    parameter logic [ADDR_BITS-1:0] BASE_ADDRESS = 12'd8,
    parameter logic [ADDR_BITS-1:0] IDLE_ADDRESS = 12'hFFF,
    parameter int                   HOLD_CYCLES  = 2
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [NUM_NEURONS-1:0] spike_vector,
    input  logic                   spike_load,
    input  logic                   clear,
    output logic [ADDR_BITS-1:0]   source_address,
    output logic                   addr_valid,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_SCAN = 3'd1;
    localparam logic [2:0] ST_SEND = 3'd2;
    localparam logic [2:0] ST_GAP  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    logic [2:0]             state;
    logic [2:0]             next_state;
    logic [NUM_NEURONS-1:0] pending;
    logic [NUM_NEURONS-1:0] low_bit;
    logic [NUM_NEURONS-1:0] pend_kept;
    logic [NUM_NEURONS-1:0] load_vec;
    logic [ADDR_BITS-1:0]   low_idx;
    logic [CNT_W-1:0]       hold_cnt;
    logic                   hold_last;

    // Lowest set bit as a one-hot mask (for clearing) and as an index (for the address).
    assign low_bit = pending & (~pending + NUM_NEURONS'(1));

    always_comb begin
        low_idx = '0;
        for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
            if (pending[i]) low_idx = ADDR_BITS'(i);
        end
    end

    // A load in the SCAN cycle merges into the already-cleared bitmap, so bit k may be re-sent.
    assign pend_kept = (state == ST_SCAN) ? (pending & ~low_bit) : pending;
    assign load_vec  = spike_load ? spike_vector : '0;
    assign hold_last = (hold_cnt == CNT_W'(HOLD_CYCLES - 1));

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (spike_load) next_state = ST_SCAN;
            ST_SCAN: next_state = (pending == '0) ? ST_DONE : ST_SEND;
            ST_SEND: if (!clear && hold_last) next_state = ST_GAP;
            ST_GAP:  next_state = ST_SCAN;
            ST_DONE: next_state = (spike_load || pending != '0) ? ST_SCAN : ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state          <= ST_IDLE;
            pending        <= '0;
            hold_cnt       <= '0;
            source_address <= IDLE_ADDRESS;
            addr_valid     <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            state   <= next_state;
            pending <= pend_kept | load_vec;
            busy    <= (next_state != ST_IDLE);
            done    <= (next_state == ST_DONE);
            if (spike_load && (pend_kept & spike_vector) != '0) overflow <= 1'b1;
            case (state)
                ST_SCAN: begin
                    if (pending != '0) begin
                        source_address <= BASE_ADDRESS + low_idx;
                        addr_valid     <= 1'b1;
                        hold_cnt       <= '0;
                    end
                end
                ST_SEND: begin
                    if (!clear) begin
                        if (hold_last) begin
                            source_address <= IDLE_ADDRESS;
                            addr_valid     <= 1'b0;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
